// File: rtl/lut_pkg.sv
// Shared definitions for the LUT neuron loader.
// Provides the default LUT geometry and the loader FSM state type.
// Optional build macro used by the loader: LUT_LOAD_CHECKSUM_EN.
package lut_pkg;

  // Default LUT address width (packed neuron inputs) and entry width (neuron output).
  localparam int unsigned IN_BITS_DEF  = 8;
  localparam int unsigned OUT_BITS_DEF = 2;

  // StIdle: table invalid; StLoad: accepting entry beats; StRun: lookups enabled.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StRun  = 2'd2
  } state_e;

endpackage

// File: rtl/lut_ram.sv
// Table storage for the LUT neuron.
// 2^ADDR_BITS x DATA_BITS distributed RAM, one write port, one synchronous read port.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - synchronous active-low reset (clears the read register only)
//   i_we    - write enable;  i_waddr / i_wdata - write address / data
//   i_re    - read enable;   i_raddr - read address
//   o_rdata - registered read data, holds its value when i_re is low
module lut_ram
  import lut_pkg::*;
#(
  parameter int unsigned ADDR_BITS = IN_BITS_DEF,
  parameter int unsigned DATA_BITS = OUT_BITS_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [ADDR_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0] i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0] o_rdata
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  // Contents are deliberately not reset: a full load is required after reset anyway.
  logic [DATA_BITS-1:0] r_mem [Depth];
  logic [DATA_BITS-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lut_neuron_loader.sv
// LUT neuron with a streaming table loader.
// cfg_start begins a load; 2^IN_BITS beats are written in ascending address order, after
// which lookups are served with one cycle of latency, one per cycle.
// Ports:
//   clk, rst_n              - clock and synchronous active-low reset
//   cfg_start               - pulse: (re)start a table load at address 0
//   cfg_valid/cfg_ready     - entry beat handshake; cfg_data - entry value
//   load_done               - high exactly while lookups are enabled
//   in_valid/in_data        - lookup request and address
//   out_valid/out_data      - registered lookup result
// Build option LUT_LOAD_CHECKSUM_EN adds cfg_csum (mod-256 sum of all beats, sampled on the
// final beat) and cfg_err (sticky mismatch flag, cleared by cfg_start or reset).
module lut_neuron_loader
  import lut_pkg::*;
#(
  parameter int unsigned IN_BITS  = IN_BITS_DEF,
  parameter int unsigned OUT_BITS = OUT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
`ifdef LUT_LOAD_CHECKSUM_EN
  input  logic [7:0]          cfg_csum,
  output logic                cfg_err,
`endif
  output logic                load_done,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  state_e              r_state;
  state_e              w_state_next;
  logic [IN_BITS-1:0]  r_addr;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_csum_ok;
  logic                w_rd_en;
  logic                r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // cfg_start wins over a coincident beat, which is dropped.
  always_comb begin
    w_state_next = r_state;
    cfg_ready    = 1'b0;
    load_done    = 1'b0;
    w_beat       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cfg_start) w_state_next = StLoad;
      end
      StLoad: begin
        cfg_ready = 1'b1;
        if (cfg_start) begin
          w_state_next = StLoad;
        end else if (cfg_valid) begin
          w_beat = 1'b1;
          if (r_addr == '1) w_state_next = w_csum_ok ? StRun : StIdle;
        end
      end
      StRun: begin
        load_done = 1'b1;
        if (cfg_start) w_state_next = StLoad;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_last_beat = w_beat && (r_addr == '1);

  // Cleared on the final beat too, so the counter never starts a second pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (cfg_start || w_last_beat) begin
      r_addr <= '0;
    end else if (w_beat) begin
      r_addr <= r_addr + IN_BITS'(1);
    end
  end

`ifdef LUT_LOAD_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;
  logic       r_err;

  always_comb begin
    w_sum_next = r_sum + 8'(cfg_data);
    w_csum_ok  = (w_sum_next == cfg_csum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (cfg_start) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_beat) begin
      r_sum <= w_sum_next;
      if (w_last_beat && !w_csum_ok) r_err <= 1'b1;
    end
  end

  assign cfg_err = r_err;
`else
  assign w_csum_ok = 1'b1;
`endif

  // A lookup coinciding with cfg_start in RUN still reads the old table: writes only
  // begin once the FSM is in LOAD.
  assign w_rd_en = (r_state == StRun) && in_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_en;
    end
  end

  lut_ram #(
    .ADDR_BITS (IN_BITS),
    .DATA_BITS (OUT_BITS)
  ) u_lut_ram (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_beat),
    .i_waddr (r_addr),
    .i_wdata (cfg_data),
    .i_re    (w_rd_en),
    .i_raddr (in_data),
    .o_rdata (out_data)
  );

  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader.
// Expected lookup results come from a bench-side table model and are queued with the cycle
// they are due; a monitor on the falling edge pops and compares them against the DUT.
// Define LUT_LOAD_CHECKSUM_EN to also exercise the checksum option.
module tb_lut_neuron_loader;
  import lut_pkg::*;

  localparam int unsigned IB = IN_BITS_DEF;
  localparam int unsigned OB = OUT_BITS_DEF;
  localparam int unsigned N  = 1 << IB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [OB-1:0] cfg_data = '0;
  logic          load_done;
  logic          in_valid = 1'b0;
  logic [IB-1:0] in_data = '0;
  logic          out_valid;
  logic [OB-1:0] out_data;
`ifdef LUT_LOAD_CHECKSUM_EN
  logic [7:0]    cfg_csum = '0;
  logic          cfg_err;
`endif

  always #5 clk = ~clk;

  lut_neuron_loader #(
    .IN_BITS  (IB),
    .OUT_BITS (OB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
`ifdef LUT_LOAD_CHECKSUM_EN
    .cfg_csum  (cfg_csum),
    .cfg_err   (cfg_err),
`endif
    .load_done (load_done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  typedef struct {
    int unsigned   due;
    logic [OB-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int unsigned   cyc = 0;
  logic [OB-1:0] model[N];     // table the DUT should hold when enabled
  logic [OB-1:0] next_tbl[N];  // table being streamed in
  bit            model_run = 1'b0;
  bit            csum_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every out_valid must match the oldest queued expectation on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL lookup_unexpected cyc=%0d out_valid=1 required=0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.due != cyc || out_data !== e.data) begin
          failures++;
          $display("FAIL lookup_data cyc=%0d actual=%0h required=%0h due=%0d",
                   cyc, out_data, e.data, e.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL lookup_missing cyc=%0d out_valid=%b required=1", cyc, out_valid);
      e = exp_q.pop_front();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [IB-1:0] a);
    in_valid = 1'b1;
    in_data  = a;
    if (model_run) exp_q.push_back('{due: cyc + 1, data: model[a]});
    tick();
  endtask

  task automatic sweep();
    for (int a = 0; a < int'(N); a++) lookup(IB'(a));
    in_valid = 1'b0;
    repeat (2) tick();
  endtask

  // Pulse cfg_start (with a coincident junk beat and a lookup), then stream nb beats of
  // next_tbl with cfg_valid asserted on duty% of cycles.
  task automatic do_load(input int duty, input int nb);
    int         beat;
    int         guard;
    logic [7:0] sum;
    beat  = 0;
    guard = 0;
    sum   = '0;
    for (int i = 0; i < int'(N); i++) sum = sum + 8'(next_tbl[i]);
`ifdef LUT_LOAD_CHECKSUM_EN
    cfg_csum = sum + (csum_bad ? 8'd1 : 8'd0);
`endif
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = ~next_tbl[0];
    lookup(IB'($urandom_range(0, N - 1)));
    model_run = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    while (beat < nb && guard < 5000) begin
      cfg_valid = ($urandom_range(0, 99) < duty);
      cfg_data  = next_tbl[beat];
      @(negedge clk);
      chk("load_ready_done", 32'({cfg_ready, load_done}), 32'd2);
      tick();
      if (cfg_valid) beat++;
      guard++;
    end
    cfg_valid = 1'b0;
    if (beat < nb) chk("load_timeout", 32'(beat), 32'(nb));
    if (nb == int'(N)) begin
      if (csum_bad) begin
        chk("csum_bad_done", 32'(load_done), 32'd0);
        chk("csum_bad_ready", 32'(cfg_ready), 32'd0);
`ifdef LUT_LOAD_CHECKSUM_EN
        chk("csum_bad_err", 32'(cfg_err), 32'd1);
`endif
      end else begin
        chk("done_after_last", 32'(load_done), 32'd1);
        chk("ready_after_last", 32'(cfg_ready), 32'd0);
`ifdef LUT_LOAD_CHECKSUM_EN
        chk("csum_ok_err", 32'(cfg_err), 32'd0);
`endif
        model     = next_tbl;
        model_run = 1'b1;
      end
      // Extra beats after completion must not start a second pass.
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        cfg_data = ~next_tbl[i];
        tick();
      end
      cfg_valid = 1'b0;
    end
  endtask

  task automatic rand_tbl();
    for (int i = 0; i < int'(N); i++) next_tbl[i] = OB'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    repeat (3) tick();
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_done", 32'(load_done), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Lookups in IDLE are ignored.
    in_valid = 1'b1;
    in_data  = 8'h40;
    repeat (2) tick();
    @(negedge clk);
    chk("idle_no_out", 32'(out_valid), 32'd0);
    chk("idle_done", 32'(load_done), 32'd0);
    tick();
    in_valid = 1'b0;

    // Popcount pattern, full-rate load, then lookup 0x40.
    for (int i = 0; i < int'(N); i++) next_tbl[i] = OB'($countones(IB'(i)));
    do_load(100, N);
    lookup(8'h40);
    in_valid = 1'b0;
    repeat (2) tick();

    // Sparse cfg_valid; the start pulse also carries a lookup on the old table.
    rand_tbl();
    do_load(30, N);
    sweep();

    // Restart after beat 100 with a different table.
    rand_tbl();
    do_load(100, 100);
    rand_tbl();
    do_load(70, N);
    sweep();

    // Reset at beat 50: table disabled, lookups ignored.
    rand_tbl();
    do_load(100, 50);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = IB'($urandom);
    repeat (2) tick();
    @(negedge clk);
    chk("midreset_done", 32'(load_done), 32'd0);
    chk("midreset_ready", 32'(cfg_ready), 32'd0);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = IB'($urandom);
      tick();
      @(negedge clk);
      chk("postreset_out_valid", 32'(out_valid), 32'd0);
      chk("postreset_done", 32'(load_done), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    rand_tbl();
    do_load(50, N);
    sweep();

`ifdef LUT_LOAD_CHECKSUM_EN
    // Checksum off by one: error, back to IDLE, lookups ignored.
    csum_bad = 1'b1;
    rand_tbl();
    do_load(100, N);
    for (int i = 0; i < 4; i++) lookup(IB'($urandom));
    in_valid = 1'b0;
    @(negedge clk);
    chk("csum_err_sticky", 32'(cfg_err), 32'd1);
    chk("csum_err_done", 32'(load_done), 32'd0);
    tick();
    csum_bad = 1'b0;
    rand_tbl();
    do_load(100, N);
    sweep();
`endif

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
